fmc_i2c_init_sequencer: RTL
===========================

Name: fmc_i2c_init_sequencer

Overview:
Table-driven sequencer that configures the FMC424 at power-up by walking a list of I2C register-write transactions and issuing them one at a time to the byte-level I2C master (fmc_i2c_controller) through a valid/ready command port. Targets include the CPLD control register (0x3E), the SI5338B (0x70) and the QSFP modules (0x50). The transaction list lives in an external synchronous ROM. The block handles NACK retry, response timeout, inter-transaction gap and done/error reporting to system control.

Parameters:
NUM_ENTRIES, 16, maximum table depth; hard end of the walk if no entry sets the last bit
IDX_W, 4, table index width; must satisfy 2**IDX_W >= NUM_ENTRIES
MAX_RETRIES, 3, re-issues allowed per entry after a NACK or timeout (0 = no retry)
GAP_CYCLES, 1000, idle CLK cycles between a response and the next command issue, including retries; minimum 1
RSP_TIMEOUT, 65535, CLK cycles in WAIT_RSP with no rsp_valid before the entry is treated as NACK

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; begins the walk at entry 0
tbl_addr  out  IDX_W  ROM read address, registered
tbl_data  in  24  ROM word, valid 1 cycle after tbl_addr: [23] last, [22:16] dev_addr, [15:8] reg_addr, [7:0] wr_data
cmd_valid  out  1  command to I2C master valid
cmd_ready  in  1  I2C master accepts command
cmd_rw  out  1  0 = write, 1 = read
cmd_dev_addr  out  7  7-bit I2C device address
cmd_reg_addr  out  8  register address
cmd_wr_data  out  8  write data
rsp_valid  in  1  transaction complete, 1-cycle pulse
rsp_nack  in  1  qualifies rsp_valid; 1 = NACK or arbitration failure
rsp_rd_data  in  8  read data, qualified by rsp_valid
busy  out  1  walk in progress
done  out  1  sticky; walk completed successfully
error  out  1  sticky; walk aborted
err_index  out  IDX_W  entry index that failed, valid while error=1

Behaviour:
- Reset: RST is synchronous and active-high, with one clock CLK. On reset, state=IDLE. All outputs are 0: tbl_addr, cmd_*, busy, done, error, err_index. Retry and gap counters are cleared. Reset asserted mid-transaction abandons the walk immediately. cmd_valid drops on the next edge. A late rsp_valid is ignored.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT_RSP, GAP, DONE, ERROR. VERIFY_ISSUE and VERIFY_WAIT exist only with the optional feature.
- IDLE, DONE or ERROR + start=1: idx<=0, tbl_addr<=0, retry<=0. done and error clear, busy<=1, next state FETCH. start in any other state is ignored.
- FETCH (1 cycle): the ROM is reading. Go to LOAD.
- LOAD (1 cycle): capture tbl_data into the cmd_* registers and the last flag. Set cmd_rw<=0 and cmd_valid<=1, then go to ISSUE. cmd_valid is therefore high exactly 3 cycles after the edge that sampled start.
- ISSUE: hold cmd_valid and all cmd_* fields stable until cmd_valid&&cmd_ready. On that edge, cmd_valid<=0, clear the timeout counter and go to WAIT_RSP.
- WAIT_RSP:
  - rsp_valid && !rsp_nack: success.
  - rsp_valid && rsp_nack, or timeout counter reaching RSP_TIMEOUT: failure.
  - rsp_valid outside WAIT_RSP and VERIFY_WAIT is ignored.
- Success:
  - If last=1 or idx==NUM_ENTRIES-1: go to DONE with done<=1 and busy<=0.
  - Otherwise: idx<=idx+1, tbl_addr<=idx+1, retry<=0, then GAP followed by FETCH.
- Failure:
  - If retry<MAX_RETRIES: retry<=retry+1, then GAP, then re-enter ISSUE with unchanged cmd_* fields.
  - Otherwise: go to ERROR with error<=1, err_index<=idx and busy<=0.
- GAP: counts GAP_CYCLES cycles, then continues to FETCH (next entry) or ISSUE (retry).
- idx never wraps. An entry with dev_addr==0 is issued like any other entry.

Optional Feature:
Macro: FMC_I2C_READBACK_VERIFY_EN.
- Defined:
  - After a successful write, go to VERIFY_ISSUE. Issue cmd_rw=1 with the same dev_addr and reg_addr, using the same handshake rules, then go to VERIFY_WAIT.
  - VERIFY_WAIT applies the same NACK and timeout rules as WAIT_RSP.
  - rsp_rd_data==wr_data counts as success for the entry.
  - A mismatch counts as a failure and consumes one retry. The retry restarts from the write.
- Undefined: cmd_rw is constant 0, rsp_rd_data is unused, and the verify states do not exist.

Test Plan:
1. 3-entry table {0x3E,0x00,0x01}, {0x70,0xE6,0x10}, {last,0x50,0x7F,0x00}; master always ACKs; GAP_CYCLES=4 -> three commands in order; cmd_valid first high 3 cycles after start; done=1, busy=0, error=0.
2. Entry 1 NACKs twice, then ACKs; MAX_RETRIES=3 -> entry 1 issued 3 times with identical fields and 4-cycle gaps; done=1.
3. Entry 0 always NACKs -> 4 issues, then error=1, err_index=0, and no command for entry 1.
4. Hold cmd_ready=0 for 10 cycles -> cmd_valid and fields stable throughout; single transfer when cmd_ready=1. Then withhold rsp_valid with RSP_TIMEOUT=20 -> counted as failure after 20 cycles.
5. Assert RST for 1 cycle while in WAIT_RSP, then send a late rsp_valid -> all outputs 0, state IDLE, late response ignored; a new start restarts at entry 0.
6. With FMC_I2C_READBACK_VERIFY_EN: write 0x10, read back 0x11 -> retry counted; read back 0x10 on retry -> entry passes, done=1.

Source files
------------

// File: rtl/fmc_i2c_init_sequencer.sv
// fmc_i2c_init_sequencer
// Walks an external synchronous ROM of I2C register writes at power-up and
// hands them one at a time to the byte-level I2C master over valid/ready.
// It handles NACK/timeout retries, an idle gap between transactions, and
// sticky done/error reporting.
// Optional read-back of every write: define FMC_I2C_READBACK_VERIFY_EN.
module fmc_i2c_init_sequencer #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int MAX_RETRIES = 3,
  parameter int GAP_CYCLES  = 1000,
  parameter int RSP_TIMEOUT = 65535
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [23:0]      tbl_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_rw,
  output logic [6:0]       cmd_dev_addr,
  output logic [7:0]       cmd_reg_addr,
  output logic [7:0]       cmd_wr_data,
  input  logic             rsp_valid,
  input  logic             rsp_nack,
  input  logic [7:0]       rsp_rd_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(RSP_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, ISSUE, WAIT_RSP, GAP, DONE, ERROR
`ifdef FMC_I2C_READBACK_VERIFY_EN
    , VERIFY_ISSUE, VERIFY_WAIT
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;      // doubles as the registered ROM address
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             vld_q, vld_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wr_q, wr_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] eidx_q, eidx_d;
  logic             ok, fail;          // entry outcome resolved this cycle

`ifdef FMC_I2C_READBACK_VERIFY_EN
  logic rw_q, rw_d;
  assign cmd_rw = rw_q;
`else
  logic unused_rd;
  assign cmd_rw    = 1'b0;
  assign unused_rd = ^rsp_rd_data;
`endif

  assign tbl_addr     = idx_q;
  assign cmd_valid    = vld_q;
  assign cmd_dev_addr = dev_q;
  assign cmd_reg_addr = reg_q;
  assign cmd_wr_data  = wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign err_index    = eidx_q;

  // Next-state and register updates for the table walk.
  always_comb begin
    state_d = state_q; idx_d = idx_q; rty_d = rty_q; gap_d = gap_q;
    tmo_d = tmo_q; vld_d = vld_q; dev_d = dev_q; reg_d = reg_q;
    wr_d = wr_q; last_d = last_q; busy_d = busy_q; done_d = done_q;
    err_d = err_q; eidx_d = eidx_q; ok = 1'b0; fail = 1'b0;
`ifdef FMC_I2C_READBACK_VERIFY_EN
    rw_d = rw_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          idx_d = '0; rty_d = '0; eidx_d = '0;
          done_d = 1'b0; err_d = 1'b0; busy_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        last_d = tbl_data[23]; dev_d = tbl_data[22:16];
        reg_d = tbl_data[15:8]; wr_d = tbl_data[7:0];
        vld_d = 1'b1; state_d = ISSUE;
`ifdef FMC_I2C_READBACK_VERIFY_EN
        rw_d = 1'b0;
`endif
      end
      ISSUE: begin
        if (cmd_ready) begin vld_d = 1'b0; tmo_d = '0; state_d = WAIT_RSP; end
      end
      WAIT_RSP: begin
        if (rsp_valid && !rsp_nack) begin
`ifdef FMC_I2C_READBACK_VERIFY_EN
          vld_d = 1'b1; rw_d = 1'b1; state_d = VERIFY_ISSUE;
`else
          ok = 1'b1;
`endif
        end else if (rsp_valid || tmo_q == TMO_END) fail = 1'b1;
        else tmo_d = tmo_q + 1'b1;
      end
`ifdef FMC_I2C_READBACK_VERIFY_EN
      VERIFY_ISSUE: begin
        if (cmd_ready) begin vld_d = 1'b0; tmo_d = '0; state_d = VERIFY_WAIT; end
      end
      VERIFY_WAIT: begin
        if (rsp_valid && !rsp_nack && rsp_rd_data == wr_q) ok = 1'b1;
        else if (rsp_valid || tmo_q == TMO_END) fail = 1'b1;
        else tmo_d = tmo_q + 1'b1;
      end
`endif
      GAP: begin
        if (gap_q == GAP_END) begin
          gap_d = '0;
          // a non-zero retry count means this gap follows a failure
          if (rty_q != '0) begin
            vld_d = 1'b1; state_d = ISSUE;
`ifdef FMC_I2C_READBACK_VERIFY_EN
            rw_d = 1'b0;
`endif
          end else state_d = FETCH;
        end else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (ok) begin
      if (last_q || idx_q == LAST_IDX) begin
        state_d = DONE; done_d = 1'b1; busy_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1; rty_d = '0; gap_d = '0; state_d = GAP;
      end
    end else if (fail) begin
      if (rty_q < RTY_MAX) begin
        rty_d = rty_q + 1'b1; gap_d = '0; state_d = GAP;
      end else begin
        state_d = ERROR; err_d = 1'b1; eidx_d = idx_q; busy_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE; idx_q <= '0; rty_q <= '0; gap_q <= '0; tmo_q <= '0;
      vld_q <= 1'b0; dev_q <= '0; reg_q <= '0; wr_q <= '0; last_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; eidx_q <= '0;
`ifdef FMC_I2C_READBACK_VERIFY_EN
      rw_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; idx_q <= idx_d; rty_q <= rty_d; gap_q <= gap_d;
      tmo_q <= tmo_d; vld_q <= vld_d; dev_q <= dev_d; reg_q <= reg_d;
      wr_q <= wr_d; last_q <= last_d; busy_q <= busy_d; done_q <= done_d;
      err_q <= err_d; eidx_q <= eidx_d;
`ifdef FMC_I2C_READBACK_VERIFY_EN
      rw_q <= rw_d;
`endif
    end
  end
endmodule
